forward_scheduler: RTL and testbench

Hazard and forwarding controller for the decode stage. It shadows the execute and write-back pipeline with a register-tag scoreboard. For the instruction at the decode-queue head it computes the per-operand forwarding selects consumed by `decode_phase`: `forward_to_{d,s,t}_from_exe` and `forward_to_{d,s,t}_from_wri[EW_LAYER:0]`. It also raises a load-use stall when an operand cannot yet be forwarded.

---
 rtl/forward_scheduler.sv | 123 ++++++++++++
 tb/tb_forward_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/forward_scheduler.sv
// Decode-stage hazard/forwarding controller: tracks E and W[0..EW_LAYER] destination tags and picks the youngest producer per operand.
// Selects, stall and issue are combinational (0 cycles); slots advance every edge, and a load in E stalls the head for one cycle.
// Optional FWD_PERF_CNT_EN adds stall_cnt/fwd_cnt performance counters.
module forward_scheduler #(
    parameter int EW_LAYER   = 1,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  head_valid,
    input  logic [REG_ADDR_W-1:0] head_reg_addr_d,
    input  logic [REG_ADDR_W-1:0] head_reg_addr_s,
    input  logic [REG_ADDR_W-1:0] head_reg_addr_t,
    input  logic                  head_use_d,
    input  logic                  head_use_s,
    input  logic                  head_use_t,
    input  logic                  head_writes_d,
    input  logic                  head_is_load,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  forward_to_d_from_exe,
    output logic                  forward_to_s_from_exe,
    output logic                  forward_to_t_from_exe,
    output logic [EW_LAYER:0]     forward_to_d_from_wri,
    output logic [EW_LAYER:0]     forward_to_s_from_wri,
    output logic [EW_LAYER:0]     forward_to_t_from_wri,
    output logic                  stall,
    output logic                  issue
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           fwd_cnt
`endif
);

    typedef struct packed {
        logic                  vld;
        logic [REG_ADDR_W-1:0] addr;
        logic                  is_load;
    } slot_t;

    slot_t                  e_slot;
    slot_t [EW_LAYER:0]     w_slot;

    logic [2:0][REG_ADDR_W-1:0] op_addr;
    logic [2:0]                 op_use;
    logic [2:0]                 m_e;
    logic [2:0]                 exe_sel;
    logic [2:0]                 load_hit;
    logic [2:0][EW_LAYER:0]     wri_sel;
    logic                       gate;

    assign op_addr = {head_reg_addr_t, head_reg_addr_s, head_reg_addr_d};
    assign op_use  = {head_use_t, head_use_s, head_use_d};
    assign gate    = head_valid & ~flush;

    always_comb begin
        logic seen;
        logic hit;
        seen     = 1'b0;
        hit      = 1'b0;
        m_e      = '0;
        exe_sel  = '0;
        load_hit = '0;
        wri_sel  = '0;
        for (int x = 0; x < 3; x++) begin
            m_e[x]      = op_use[x] & e_slot.vld & (e_slot.addr == op_addr[x]);
            exe_sel[x]  = gate & m_e[x] & ~e_slot.is_load;
            load_hit[x] = m_e[x] & e_slot.is_load;
            // Walk W from youngest to oldest; any younger match masks the older ones.
            seen = m_e[x];
            for (int i = 0; i <= EW_LAYER; i++) begin
                hit           = op_use[x] & w_slot[i].vld & (w_slot[i].addr == op_addr[x]);
                wri_sel[x][i] = gate & hit & ~seen;
                seen          = seen | hit;
            end
        end
    end

    assign stall = gate & (|load_hit);
    assign issue = head_valid & ~stall & ~hold & ~flush;

    assign forward_to_d_from_exe = exe_sel[0];
    assign forward_to_s_from_exe = exe_sel[1];
    assign forward_to_t_from_exe = exe_sel[2];
    assign forward_to_d_from_wri = wri_sel[0];
    assign forward_to_s_from_wri = wri_sel[1];
    assign forward_to_t_from_wri = wri_sel[2];

    // The back end never stalls: W shifts unconditionally, E takes a bubble whenever nothing issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_slot <= '0;
            w_slot <= '0;
        end else begin
            if (issue && head_writes_d)
                e_slot <= {1'b1, head_reg_addr_d, head_is_load};
            else
                e_slot <= '0;
            w_slot[0] <= e_slot;
            for (int i = 1; i <= EW_LAYER; i++)
                w_slot[i] <= w_slot[i-1];
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic fwd_any;
    assign fwd_any = (|exe_sel) | (|wri_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall)
                stall_cnt <= stall_cnt + 32'd1;
            if (fwd_any)
                fwd_cnt <= fwd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_forward_scheduler.sv
// Bench for forward_scheduler: directed scenarios with literal expectations plus random traffic against an issue-history model.
module tb_forward_scheduler;
    localparam int EW = 1;
    localparam int AW = 5;
    localparam int OW = 3 + 3*(EW+1) + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          head_valid;
    logic [AW-1:0] head_reg_addr_d, head_reg_addr_s, head_reg_addr_t;
    logic          head_use_d, head_use_s, head_use_t;
    logic          head_writes_d, head_is_load, hold, flush;
    logic          fd_e, fs_e, ft_e;
    logic [EW:0]   fd_w, fs_w, ft_w;
    logic          stall, issue;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]   stall_cnt, fwd_cnt;
`endif

    int checks = 0;
    int errors = 0;

    forward_scheduler #(.EW_LAYER(EW), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .head_valid(head_valid),
        .head_reg_addr_d(head_reg_addr_d), .head_reg_addr_s(head_reg_addr_s),
        .head_reg_addr_t(head_reg_addr_t),
        .head_use_d(head_use_d), .head_use_s(head_use_s), .head_use_t(head_use_t),
        .head_writes_d(head_writes_d), .head_is_load(head_is_load),
        .hold(hold), .flush(flush),
        .forward_to_d_from_exe(fd_e), .forward_to_s_from_exe(fs_e),
        .forward_to_t_from_exe(ft_e),
        .forward_to_d_from_wri(fd_w), .forward_to_s_from_wri(fs_w),
        .forward_to_t_from_wri(ft_w),
        .stall(stall), .issue(issue)
`ifdef FWD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    // hist[k] = destination written by the instruction issued k edges ago (bubble if none).
    typedef struct {
        bit            vld;
        logic [AW-1:0] addr;
        bit            ld;
    } prod_t;
    prod_t hist[1:EW+2];

    function automatic logic [OW-1:0] model_out();
        logic [2:0]        ex;
        logic [2:0][EW:0]  wr;
        logic              st, iss, found;
        logic [AW-1:0]     a[3];
        logic              u[3];
        a[0] = head_reg_addr_d; a[1] = head_reg_addr_s; a[2] = head_reg_addr_t;
        u[0] = head_use_d;      u[1] = head_use_s;      u[2] = head_use_t;
        ex = '0; wr = '0; st = 1'b0;
        for (int x = 0; x < 3; x++) begin
            found = 1'b0;
            if (head_valid && !flush && u[x]) begin
                for (int age = 1; age <= EW+2; age++) begin
                    if (!found && hist[age].vld && hist[age].addr == a[x]) begin
                        found = 1'b1;
                        if (age == 1) begin
                            if (hist[age].ld) st = 1'b1;
                            else              ex[x] = 1'b1;
                        end else begin
                            wr[x][age-2] = 1'b1;
                        end
                    end
                end
            end
        end
        iss = head_valid && !st && !hold && !flush;
        return {ex, wr, st, iss};
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [OW-1:0] o;
        if (rst) begin
            for (int k = 1; k <= EW+2; k++) hist[k] = '{vld: 1'b0, addr: '0, ld: 1'b0};
        end else begin
            o = model_out();
            for (int k = EW+2; k > 1; k--) hist[k] = hist[k-1];
            hist[1] = '{vld: o[0] && head_writes_d, addr: head_reg_addr_d, ld: head_is_load};
        end
    end

    always @(negedge clk) begin
        logic [OW-1:0] act, exp_o;
        if (!rst) begin
            act   = {ft_e, fs_e, fd_e, ft_w, fs_w, fd_w, stall, issue};
            exp_o = model_out();
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("FAIL model_cmp t=%0t: got %b expected %b", $time, act, exp_o);
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        head_valid = 0; head_reg_addr_d = 0; head_reg_addr_s = 0; head_reg_addr_t = 0;
        head_use_d = 0; head_use_s = 0; head_use_t = 0;
        head_writes_d = 0; head_is_load = 0; hold = 0; flush = 0;
    endtask

    task automatic set_head(input logic [AW-1:0] d, s, t, input logic ud, us, ut, wd, ld);
        head_valid = 1; head_reg_addr_d = d; head_reg_addr_s = s; head_reg_addr_t = t;
        head_use_d = ud; head_use_s = us; head_use_t = ut;
        head_writes_d = wd; head_is_load = ld; hold = 0; flush = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        set_head(1, 1, 1, 1, 1, 1, 1, 0);
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_sel", {fd_e, fs_e, ft_e, fd_w, fs_w, ft_w}, 0);
        chk("rst_issue", issue, 1);
`ifdef FWD_PERF_CNT_EN
        chk("rst_cnt", stall_cnt | fwd_cnt, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 0;
        idle();

        // ALU back-to-back
        set_head(3, 0, 0, 0, 0, 0, 1, 0); #2;
        chk("alu_issue", issue, 1);
        cyc(); set_head(4, 3, 0, 0, 1, 0, 1, 0); #2;
        chk("alu_fs_e", fs_e, 1);
        chk("alu_fs_w", fs_w, 0);
        chk("alu_stall", stall, 0);

        // Load-use
        cyc(); idle(); repeat (3) cyc();
        set_head(5, 0, 0, 0, 0, 0, 1, 1);
        cyc(); set_head(6, 0, 5, 0, 0, 1, 1, 0); #2;
        chk("ld_c1_stall", stall, 1);
        chk("ld_c1_issue", issue, 0);
        chk("ld_c1_sel", {ft_e, ft_w}, 0);
        cyc(); #2;
        chk("ld_c2_ft_w", ft_w, 2'b01);
        chk("ld_c2_stall", stall, 0);
        chk("ld_c2_issue", issue, 1);
        cyc(); idle();
`ifdef FWD_PERF_CNT_EN
        #2;
        chk("cnt_stall", stall_cnt, 1);
        chk("cnt_fwd", fwd_cnt, 2);
`endif

        // Age priority
        repeat (4) cyc();
        set_head(2, 0, 0, 0, 0, 0, 1, 0);
        cyc(); set_head(2, 2, 0, 0, 1, 0, 1, 0);
        cyc(); set_head(2, 0, 0, 1, 0, 0, 0, 0); #2;
        chk("age_fd_e", fd_e, 1);
        chk("age_fd_w", fd_w, 0);

        // Retirement
        cyc(); idle(); repeat (4) cyc();
        set_head(7, 0, 0, 0, 0, 0, 1, 0);
        cyc(); idle();
        cyc(); set_head(0, 7, 0, 0, 1, 0, 0, 0); #2;
        chk("ret_w0", fs_w, 2'b01);
        cyc(); #2;
        chk("ret_w1", fs_w, 2'b10);
        chk("ret_e", fs_e, 0);
        cyc(); #2;
        chk("ret_gone", {fs_e, fs_w}, 0);

        // Flush during hazard
        cyc(); idle(); repeat (4) cyc();
        set_head(5, 0, 0, 0, 0, 0, 1, 1);
        cyc(); set_head(6, 0, 5, 0, 0, 1, 1, 0); flush = 1; #2;
        chk("fl_stall", stall, 0);
        chk("fl_issue", issue, 0);
        chk("fl_sel", {ft_e, ft_w}, 0);
        cyc(); flush = 0; #2;
        chk("fl_next_w", {ft_e, ft_w}, 3'b001);
        chk("fl_next_stall", stall, 0);

        // Reset mid-stall
        cyc(); idle(); repeat (3) cyc();
        set_head(5, 0, 0, 0, 0, 0, 1, 1);
        cyc(); set_head(6, 0, 5, 0, 0, 1, 1, 0); #2;
        chk("rs_pre_stall", stall, 1);
        #1 rst = 1; #1;
        chk("rs_stall", stall, 0);
        chk("rs_sel", {ft_e, ft_w}, 0);
        cyc(); cyc(); rst = 0; #2;
        chk("rs_after_sel", {ft_e, ft_w}, 0);
        chk("rs_after_stall", stall, 0);

        // Random traffic, checked every cycle by the model comparator
        cyc(); idle();
        for (int n = 0; n < 3000; n++) begin
            head_valid      = ($urandom_range(0, 7) != 0);
            head_reg_addr_d = AW'($urandom_range(0, 3));
            head_reg_addr_s = AW'($urandom_range(0, 3));
            head_reg_addr_t = AW'($urandom_range(0, 3));
            head_use_d      = $urandom_range(0, 1);
            head_use_s      = $urandom_range(0, 1);
            head_use_t      = $urandom_range(0, 1);
            head_writes_d   = ($urandom_range(0, 3) != 0);
            head_is_load    = ($urandom_range(0, 3) == 0);
            hold            = ($urandom_range(0, 7) == 0);
            flush           = ($urandom_range(0, 15) == 0);
            cyc();
        end
        idle();
        cyc(); cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
